// File: rtl/ram_sp_be_init.sv
// rtl/ram_sp_be_init.sv - single-port RAM with column byte-enables, post-reset clear and sticky errors
module ram_sp_be_init #(
   parameter int                ADR_WD   = 8,
   parameter int                DEPTH    = 240,
   parameter int                DAT_WD   = 32,
   parameter int                COL_WD   = 8,
   parameter logic [DAT_WD-1:0] INIT_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADR_WD-1:0]        adr_i,
   input  logic                     wr_ena_i,
   input  logic [DAT_WD/COL_WD-1:0] wr_be_i,
   input  logic [DAT_WD-1:0]        wr_dat_i,
   input  logic                     rd_ena_i,
   output logic [DAT_WD-1:0]        rd_dat_o,
   output logic                     rd_vld_o,
   output logic                     init_done_o,
   output logic                     err_o
);

   localparam int NCOL = DAT_WD / COL_WD;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state, state_nxt;
   logic [ADR_WD-1:0]   cnt, cnt_nxt;
   logic [DAT_WD-1:0]   mem [DEPTH];

   logic                in_range;
   logic                mem_we;
   logic [ADR_WD-1:0]   mem_adr;
   logic [DAT_WD-1:0]   mem_dat;
   logic [NCOL-1:0]     mem_be;
   logic                rd_acc;
   logic                req_err;

   logic                rd_pend;
   logic                err_pend;
   logic [DAT_WD-1:0]   rd_word;

   // Extra bit keeps the compare correct when DEPTH == 2**ADR_WD
   assign in_range = {1'b0, adr_i} < (ADR_WD+1)'(DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == ST_INIT) begin
         cnt_nxt = cnt + ADR_WD'(1);
         if (cnt == ADR_WD'(DEPTH - 1)) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      end
   end

   // Memory port arbitration: clear owns the port in INIT, write wins over read in RUN
   always_comb begin
      init_done_o = (state == ST_RUN);
      mem_we      = 1'b0;
      mem_adr     = cnt;
      mem_dat     = INIT_VAL;
      mem_be      = '1;
      rd_acc      = 1'b0;
      req_err     = 1'b0;
      if (state == ST_INIT) begin
         mem_we  = 1'b1;
         req_err = wr_ena_i | rd_ena_i;
      end else if (wr_ena_i) begin
         mem_we  = in_range;
         mem_adr = adr_i;
         mem_dat = wr_dat_i;
         mem_be  = wr_be_i;
         req_err = !in_range;
      end else if (rd_ena_i) begin
         rd_acc  = 1'b1;
         req_err = !in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int k = 0; k < NCOL; k++) begin
            if (mem_be[k]) begin
               mem[mem_adr][k*COL_WD +: COL_WD] <= mem_dat[k*COL_WD +: COL_WD];
            end
         end
      end
      if (rd_acc) begin
         rd_word <= in_range ? mem[adr_i] : '0;
      end
   end

   // Hold stage: rd_dat_o only moves on an accepted read, so write-only cycles leave it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         err_pend <= 1'b0;
         rd_vld_o <= 1'b0;
         rd_dat_o <= '0;
         err_o    <= 1'b0;
      end else begin
         rd_pend  <= rd_acc;
         err_pend <= req_err;
         rd_vld_o <= rd_pend;
         if (rd_pend) begin
            rd_dat_o <= rd_word;
         end
         err_o    <= err_o | err_pend;
      end
   end

endmodule

// File: tb/tb_ram_sp_be_init.sv
// tb/tb_ram_sp_be_init.sv - randomized self-checking bench for ram_sp_be_init
module tb_ram_sp_be_init;

   localparam int          DEPTH = 240;
   localparam logic [31:0] IVAL  = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  adr;
   logic        wr_ena;
   logic [3:0]  wr_be;
   logic [31:0] wr_dat;
   logic        rd_ena;
   logic [31:0] rd_dat;
   logic        rd_vld;
   logic        init_done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [DEPTH];
   int          clr = 0;
   bit          pend_vld, pend_err;
   logic [31:0] pend_dat;
   bit          exp_vld, exp_err, exp_done;
   logic [31:0] exp_dat;

   always #5 clk = ~clk;

   ram_sp_be_init #(
      .ADR_WD(8), .DEPTH(DEPTH), .DAT_WD(32), .COL_WD(8), .INIT_VAL(IVAL)
   ) dut (
      .clk(clk), .rst(rst), .adr_i(adr), .wr_ena_i(wr_ena), .wr_be_i(wr_be),
      .wr_dat_i(wr_dat), .rd_ena_i(rd_ena), .rd_dat_o(rd_dat), .rd_vld_o(rd_vld),
      .init_done_o(init_done), .err_o(err)
   );

   // One clock: drive request, advance the reference model at the edge, sample 1ns later
   task automatic tick(input bit r, input bit w, input bit rd, input int a,
                       input logic [3:0] be, input logic [31:0] d);
      rst = r; wr_ena = w; rd_ena = rd; adr = a[7:0]; wr_be = be; wr_dat = d;
      @(posedge clk);
      if (r) begin
         clr = 0; pend_vld = 0; pend_err = 0;
         exp_vld = 0; exp_dat = '0; exp_err = 0;
      end else begin
         exp_vld = pend_vld;
         if (pend_vld) exp_dat = pend_dat;
         exp_err = exp_err | pend_err;
         pend_vld = 0; pend_err = 0;
         if (clr < DEPTH) begin
            ref_mem[clr] = IVAL;
            clr++;
            pend_err = w | rd;
         end else if (w) begin
            if (a < DEPTH) begin
               for (int k = 0; k < 4; k++) if (be[k]) ref_mem[a][k*8 +: 8] = d[k*8 +: 8];
            end else begin
               pend_err = 1;
            end
         end else if (rd) begin
            pend_vld = 1;
            pend_dat = (a < DEPTH) ? ref_mem[a] : 32'h0;
            pend_err = (a >= DEPTH);
         end
      end
      exp_done = (clr >= DEPTH);
      #1;
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 4'h0, 32'h0);
   endtask

   task automatic rd_word(input int a);
      tick(0, 0, 1, a, 4'h0, 32'h0);
   endtask

   task automatic wait_done(output int n, output bit saw_vld);
      n = 0; saw_vld = 0;
      while (!init_done && n < 1000) begin
         idle();
         n++;
         if (rd_vld) saw_vld = 1;
      end
   endtask

   task automatic test_reset();
      int n; bit sv;
      repeat (3) tick(1, 0, 0, 0, 4'h0, 32'h0);
      checks++; if (rd_dat !== 32'h0) begin errors++; $display("FAIL reset_rd_dat: got %h expected 0", rd_dat); end
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      wait_done(n, sv);
      checks++; if (n != 240) begin errors++; $display("FAIL init_latency: got %0d cycles expected 240", n); end
      checks++; if (sv) begin errors++; $display("FAIL init_no_vld: got vld pulse expected none"); end
      foreach (ref_mem[i]) if (i == 0 || i == 119 || i == 239) begin
         rd_word(i); idle();
         checks++;
         if (rd_vld !== 1'b1 || rd_dat !== IVAL) begin
            errors++; $display("FAIL init_value[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, rd_vld, rd_dat, IVAL);
         end
      end
   endtask

   task automatic test_byte_enable();
      tick(0, 1, 0, 5, 4'b1111, 32'h11223344);
      tick(0, 1, 0, 5, 4'b0101, 32'hFFEEDDCC);
      rd_word(5); idle();
      checks++;
      if (rd_vld !== 1'b1 || rd_dat !== 32'h11EE33CC) begin
         errors++; $display("FAIL byte_enable: got vld=%b dat=%h expected vld=1 dat=11ee33cc", rd_vld, rd_dat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [3];
      foreach (d[i]) begin
         d[i] = $urandom;
         tick(0, 1, 0, i + 1, 4'hF, d[i]);
      end
      rd_word(1); rd_word(2);
      checks++; if (rd_vld !== 1'b1 || rd_dat !== d[0]) begin errors++; $display("FAIL b2b_word1: got vld=%b dat=%h expected vld=1 dat=%h", rd_vld, rd_dat, d[0]); end
      rd_word(3);
      checks++; if (rd_vld !== 1'b1 || rd_dat !== d[1]) begin errors++; $display("FAIL b2b_word2: got vld=%b dat=%h expected vld=1 dat=%h", rd_vld, rd_dat, d[1]); end
      tick(0, 1, 0, 4, 4'hF, $urandom);
      checks++; if (rd_vld !== 1'b1 || rd_dat !== d[2]) begin errors++; $display("FAIL b2b_word3: got vld=%b dat=%h expected vld=1 dat=%h", rd_vld, rd_dat, d[2]); end
      idle();
      checks++; if (rd_vld !== 1'b0 || rd_dat !== d[2]) begin errors++; $display("FAIL b2b_hold: got vld=%b dat=%h expected vld=0 dat=%h", rd_vld, rd_dat, d[2]); end
   endtask

   task automatic test_simultaneous();
      tick(0, 1, 1, 7, 4'hF, 32'hDEADBEEF);
      repeat (2) begin
         idle();
         checks++; if (rd_vld !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL simul_no_read: got vld=%b err=%b expected vld=0 err=0", rd_vld, err); end
      end
      rd_word(7); idle();
      checks++; if (rd_vld !== 1'b1 || rd_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL simul_write: got vld=%b dat=%h expected vld=1 dat=deadbeef", rd_vld, rd_dat); end
   endtask

   task automatic test_errors();
      int n; bit sv;
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      repeat (10) idle();
      rd_word(3);
      idle();
      checks++; if (rd_vld !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL init_read_err: got vld=%b err=%b expected vld=0 err=1", rd_vld, err); end
      idle();
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL init_read_vld: got %b expected 0", rd_vld); end
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      wait_done(n, sv);
      checks++; if (err !== 1'b0 || n != 240) begin errors++; $display("FAIL err_cleared: got err=%b n=%0d expected err=0 n=240", err, n); end
      tick(0, 1, 0, 240, 4'hF, $urandom);
      idle();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", err); end
      foreach (ref_mem[i]) if (i == 0 || i == 112 || i == 239) begin
         rd_word(i); idle();
         checks++; if (rd_dat !== IVAL) begin errors++; $display("FAIL oor_write_mem[%0d]: got %h expected %h", i, rd_dat, IVAL); end
      end
      rd_word(255); idle();
      checks++; if (rd_vld !== 1'b1 || rd_dat !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL oor_read: got vld=%b dat=%h err=%b expected vld=1 dat=0 err=1", rd_vld, rd_dat, err); end
   endtask

   task automatic test_random();
      int n; bit sv;
      int a;
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      wait_done(n, sv);
      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH - 1);
         tick(0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, 4'($urandom), $urandom);
         checks++;
         if (rd_vld !== exp_vld || rd_dat !== exp_dat || err !== exp_err || init_done !== exp_done) begin
            errors++;
            $display("FAIL random[%0d]: got vld=%b dat=%h err=%b done=%b expected vld=%b dat=%h err=%b done=%b",
                     i, rd_vld, rd_dat, err, init_done, exp_vld, exp_dat, exp_err, exp_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n; bit sv;
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      repeat (100) idle();
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      checks++; if (init_done !== 1'b0 || rd_vld !== 1'b0) begin errors++; $display("FAIL mid_clear_reset: got done=%b vld=%b expected 0 0", init_done, rd_vld); end
      wait_done(n, sv);
      checks++; if (n != 240 || sv) begin errors++; $display("FAIL mid_clear_restart: got n=%0d vld_seen=%b expected n=240 vld_seen=0", n, sv); end
      tick(0, 0, 1, 300 - 280, 4'h0, 32'h0);
      idle();
      checks++; if (rd_vld !== 1'b1 || rd_dat !== IVAL) begin errors++; $display("FAIL mid_read_setup: got vld=%b dat=%h expected vld=1 dat=%h", rd_vld, rd_dat, IVAL); end
      tick(1, 0, 1, 0, 4'h0, 32'h0);
      tick(0, 0, 1, 10, 4'h0, 32'h0);
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL mid_read_issue: got vld=%b expected 0", rd_vld); end
      tick(1, 0, 0, 0, 4'h0, 32'h0);
      checks++;
      if (rd_vld !== 1'b0 || rd_dat !== 32'h0 || err !== 1'b0 || init_done !== 1'b0) begin
         errors++; $display("FAIL mid_read_reset: got vld=%b dat=%h err=%b done=%b expected 0 0 0 0", rd_vld, rd_dat, err, init_done);
      end
      wait_done(n, sv);
      checks++; if (n != 240 || sv) begin errors++; $display("FAIL mid_read_restart: got n=%0d vld_seen=%b expected n=240 vld_seen=0", n, sv); end
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_back_to_back();
      test_simultaneous();
      test_errors();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_sp_be_init.md
# ram_sp_be_init

Parametrised single-port RAM with column byte-enables, a post-reset hardware clear sequencer, a registered read-data hold stage with a valid strobe, and sticky access-error reporting. It replaces the fixed-size single-port buffers in the encoder datapath, such as the 240x32 line and parameter stores. Depth, data width and column width are set per instance, so one block serves every single-port buffer. Clients need no software clear pass after reset.

## Interface
Parameters:
- ADR_WD, 8, address width
- DEPTH, 240, number of words; legal addresses are 0..DEPTH-1; DEPTH <= 2**ADR_WD
- DAT_WD, 32, word width
- COL_WD, 8, byte-enable column width; DAT_WD % COL_WD == 0; COL_WD == DAT_WD gives whole-word writes
- INIT_VAL, 0, DAT_WD-bit value written to every word after reset

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- adr_i  in  ADR_WD  access address
- wr_ena_i  in  1  write request
- wr_be_i  in  DAT_WD/COL_WD  column enables; bit k covers wr_dat_i[k*COL_WD +: COL_WD]
- wr_dat_i  in  DAT_WD  write data
- rd_ena_i  in  1  read request
- rd_dat_o  out  DAT_WD  read data, registered and held
- rd_vld_o  out  1  one-cycle strobe, rd_dat_o updated this cycle
- init_done_o  out  1  clear sequence finished; requests accepted
- err_o  out  1  sticky access error

## Operation
- Two states, INIT and RUN.
  - rst forces INIT and sets the clear counter to 0.
  - INIT writes INIT_VAL to address cnt with all columns enabled, one word per cycle, cnt = 0..DEPTH-1.
  - After writing DEPTH-1, INIT moves to RUN.
  - RUN persists until the next rst.
- Client requests in INIT:
  - wr_ena_i or rd_ena_i is ignored: no memory write, no rd_vld_o.
  - The request sets err_o.
- Write in RUN (wr_ena_i=1):
  - Only columns with wr_be_i[k]=1 are updated.
  - If wr_be_i=0, nothing is written and this is not an error.
- Read in RUN (rd_ena_i=1, wr_ena_i=0): the addressed word appears on rd_dat_o next cycle.
- Simultaneous wr_ena_i and rd_ena_i: the write wins and the read is dropped. This matches single-port macro semantics. No rd_vld_o is raised and err_o is not set.
- Out-of-range address (adr_i >= DEPTH) in RUN:
  - A write is dropped.
  - A read returns all-zero rd_dat_o with rd_vld_o=1.
  - Both cases set err_o.
- err_o is sticky and clears only on rst.
- rd_dat_o holds the last read result until the next accepted read. Write-only cycles do not change it.
- Memory content is undefined between rst assertion and completion of the clear of each address.

## Timing
- Reset values: rd_dat_o=0, rd_vld_o=0, init_done_o=0, err_o=0, state INIT, cnt=0.
- Clear duration:
  - First clear write happens in the first cycle with rst low.
  - Last clear write happens DEPTH-1 cycles later.
  - init_done_o rises in the following cycle, DEPTH cycles after rst deasserts, and stays high.
  - The first client request is accepted in the cycle init_done_o is first seen high.
- Read latency is 1:
  - Read sampled at edge N gives rd_dat_o and rd_vld_o=1 after edge N+1.
  - rd_vld_o drops after edge N+2 unless another read is sampled at N+1.
  - Back-to-back reads give one word per cycle.
- Read-after-write, same address:
  - Write at edge N, read at edge N+1.
  - New data appears after edge N+2.
  - There is no same-cycle bypass because a same-cycle request is resolved by the write-wins rule.
- err_o rises one cycle after the offending request is sampled.
- rst asserted mid-clear or mid-read:
  - Next edge applies reset values.
  - Any pending rd_vld_o is cancelled.
  - The clear restarts from address 0.

## Test plan
- Reset, DEPTH=240, INIT_VAL=0xA5A5A5A5:
  - Deassert rst and read addresses 0, 119 and 239 after init_done_o.
  - Required: each read returns 0xA5A5A5A5.
  - Required: init_done_o rises exactly 240 cycles after rst drops.
- Byte enables, COL_WD=8:
  - Write 0x11223344 with be=4'b1111 to address 5, then 0xFFEEDDCC with be=4'b0101.
  - Required: a read of address 5 returns 0x11EE33CC.
- Back-to-back reads:
  - Issue reads to addresses 1, 2, 3 in consecutive cycles.
  - Required: rd_vld_o high for 3 consecutive cycles with the matching data.
  - Required: a following write-only cycle leaves rd_dat_o unchanged.
- Simultaneous wr+rd at address 7 with data 0xDEADBEEF:
  - Required: no rd_vld_o and err_o stays 0.
  - Required: a read next cycle returns 0xDEADBEEF.
- Errors:
  - Read during INIT: required no rd_vld_o and err_o=1.
  - Reset, then after init write adr=240: required memory unchanged and err_o=1.
  - Read adr=255: required rd_dat_o=0, rd_vld_o=1.
- Reset mid-operation:
  - Assert rst at clear address 100 and again one cycle after a read request.
  - Required: rd_vld_o never pulses, all outputs return to reset values, and init_done_o rises 240 cycles after the final rst drop.
